serial_adder: RTL



---
 rtl/arith_pkg.sv | 24 ++
 rtl/full_adder_cell.sv | 23 ++
 rtl/serial_adder.sv | 96 +++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: FSM encoding for the serial
// datapaths and a ceil(log2) helper for counter sizing.
package arith_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        ADD  = ST_ADD,
        DONE = ST_DONE
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Combinational one-bit full adder built from two half-adder stages
// whose carries are merged with an OR.
module full_adder_cell (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;
    logic g1;
    logic g2;

    always_comb begin
        p    = x ^ y;
        g1   = x & y;
        s    = p ^ cin;
        g2   = p & cin;
        cout = g1 | g2;
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial W-bit adder: operands are captured on start and summed
// LSB-first through one full-adder cell with a registered carry.
module serial_adder
    import arith_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         carry_out
);

    localparam int unsigned CW = (clog2(W) < 1) ? 1 : clog2(W);

    state_t        state_q;
    logic [W-1:0]  sa_q;
    logic [W-1:0]  sb_q;
    logic [W-1:0]  res_q;
    logic [W-1:0]  res_d;
    logic          c_q;
    logic [CW-1:0] cnt_q;
    logic          s;
    logic          cout;

    full_adder_cell u_fa (
        .x   (sa_q[0]),
        .y   (sb_q[0]),
        .cin (c_q),
        .s   (s),
        .cout(cout)
    );

    // Shift-then-insert form keeps W=1 legal (no [W-1:1] slice).
    always_comb begin
        res_d        = res_q >> 1;
        res_d[W-1]   = s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sa_q      <= '0;
            sb_q      <= '0;
            res_q     <= '0;
            c_q       <= 1'b0;
            cnt_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sa_q    <= a;
                        sb_q    <= b;
                        c_q     <= 1'b0;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    sa_q  <= sa_q >> 1;
                    sb_q  <= sb_q >> 1;
                    c_q   <= cout;
                    res_q <= res_d;
                    cnt_q <= cnt_q + 1'b1;
                    // The last bit is folded straight into sum so DONE shows the full result.
                    if (cnt_q == CW'(W - 1)) begin
                        state_q   <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        sum       <= res_d;
                        carry_out <= cout;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
